// File: rtl/nbit_sequential_divider_pkg.sv
// Shared definitions for the restoring divider.
// Both the RTL and the bench import these state encodings and the default width.
package nbit_sequential_divider_pkg;

   localparam int DEF_N = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/nbit_sequential_divider_cond_subtractor.sv
// Ripple-carry trial subtractor: a - b computed as a + ~b + 1.
// The final carry-out is 1 exactly when the difference is non-negative.
module Full_Adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module cond_subtractor #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         nonneg
);
   logic [W:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_bit
      Full_Adder u_fa (
         .a    (a[i]),
         .b    (~b[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   assign nonneg = carry[W];
endmodule

// File: rtl/nbit_sequential_divider.sv
// N-bit unsigned restoring divider: one quotient bit per RUN cycle, fixed N+1 cycle latency.
// Results and divByZero are registered at the completion edge and held until the next one.
module nbit_sequential_divider
   import nbit_sequential_divider_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividendIn,
   input  logic [N-1:0] divisorIn,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         divByZero
);
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N:0]    prem_q, prem_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  quo_q, quo_d;
   logic [N-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [N:0]    shifted;
   logic [N:0]    diff;
   logic          nonneg;

   // Bit N of a settled partial remainder is always 0, so folding it in is neutral.
   assign shifted = {prem_q[N] | prem_q[N-1], prem_q[N-2:0], dvd_q[N-1]};

   cond_subtractor #(.W(N + 1)) u_sub (
      .a      (shifted),
      .b      ({1'b0, dvs_q}),
      .diff   (diff),
      .nonneg (nonneg)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               cnt_d   = '0;
               prem_d  = '0;
               dvd_d   = dividendIn;
               dvs_d   = divisorIn;
            end
         end
         S_RUN: begin
            prem_d = nonneg ? diff : shifted;
            dvd_d  = {dvd_q[N-2:0], nonneg};
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               quo_d   = dvd_d;
               rem_d   = prem_d[N-1:0];
               dbz_d   = (dvs_q == '0);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign divByZero = dbz_q;

endmodule

// File: doc/nbit_sequential_divider.md
NBIT_SEQUENTIAL_DIVIDER -- requirements
Module: nbit_sequential_divider

Interface
REQ-001 The block SHALL have one parameter, N, default 8: operand, quotient and remainder width in bits, with a legal range of 2..32.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset; it is asynchronous and active-high.
REQ-004 Port start, input, 1 bit, SHALL be the request to begin a division; it is sampled only in IDLE.
REQ-005 Port dividendIn, input, N bits, SHALL be the unsigned dividend, sampled at the edge where start is accepted.
REQ-006 Port divisorIn, input, N bits, SHALL be the unsigned divisor, sampled at the same edge as dividendIn.
REQ-007 Port busy, output, 1 bit, SHALL be high while an iteration is in progress (RUN state).
REQ-008 Port done, output, 1 bit, SHALL be a one-cycle pulse marking that the results are valid.
REQ-009 Port quotient, output, N bits, SHALL be the registered quotient.
REQ-010 Port remainder, output, N bits, SHALL be the registered remainder.
REQ-011 Port divByZero, output, 1 bit, SHALL be high when the most recent completed division had a divisor of 0.

Function
REQ-012 The control FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 Transitions SHALL be:
- IDLE->RUN on start=1.
- RUN->RUN while the iteration count is below N.
- RUN->DONE after the Nth iteration.
- DONE->IDLE unconditionally after one cycle.
REQ-014 On acceptance, the block SHALL latch the operands, clear the N+1-bit partial remainder and load the iteration counter with 0.
REQ-015 Each RUN cycle SHALL perform one restoring step:
- shift {partial remainder, dividend shift register} left by 1;
- trial-subtract the divisor, zero-extended to N+1 bits;
- if the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
REQ-016 The counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap; RUN exits when it equals N-1 at an iteration edge.
REQ-017 Latency SHALL be fixed: if start is accepted at edge T, RUN spans edges T+1..T+N and done is high for the cycle after edge T+N.
REQ-018 Total latency from start to done SHALL be N+1 cycles, regardless of operand values.
REQ-019 quotient, remainder and divByZero SHALL update only at edge T+N and then hold until the next completion or reset.
REQ-020 start SHALL be ignored in RUN and DONE, with no queuing; a start held high through DONE is accepted on the first IDLE cycle.
REQ-021 A new start SHALL NOT disturb the held outputs until its own completion edge.
REQ-022 divisorIn=0 SHALL produce quotient=all ones, remainder=dividend and divByZero=1, with the same latency as a normal division (inherent to the algorithm, not special-cased).
REQ-023 The remainder SHALL always be less than the divisor when the divisor is non-zero.
REQ-024 quotient*divisor+remainder SHALL equal the dividend.
REQ-025 Changes to dividendIn and divisorIn after acceptance SHALL have no effect on the division in progress.

Reset
REQ-026 Asserting rst SHALL force IDLE immediately and clear quotient, remainder, divByZero, busy, done, the counter and all datapath registers to 0.
REQ-027 Asserting rst mid-RUN SHALL abort the division with no done pulse; the first start after rst deasserts SHALL operate normally.

Structure
REQ-028 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width SHALL live in a shared include file used by both RTL and bench.
REQ-029 The N+1-bit trial subtractor SHALL be a separate sub-module, cond_subtractor, built as a ripple chain of the existing Full_Adder with the divisor inverted and carry-in 1.
REQ-030 cond_subtractor SHALL output the difference and a non-negative flag (final carry-out).

Verification
REQ-031 100/7, N=8 -> done exactly 9 cycles after start, quotient=14, remainder=2, divByZero=0.
REQ-032 255/1 -> quotient=255, remainder=0; 3/10 -> quotient=0, remainder=3.
REQ-033 5/0 -> quotient=255, remainder=5, divByZero=1, done after 9 cycles.
REQ-034 Second start pulsed at cycle 3 of a 100/7 run -> ignored; single done; results 14/2; busy low only after RUN.
REQ-035 rst asserted at RUN cycle 4 -> all outputs 0 immediately, no done; subsequent 200/13 -> quotient=15, remainder=5.
REQ-036 Random self-check of 10000 operand pairs against the quotient*divisor+remainder identity and the remainder<divisor bound -> zero mismatches.
